// File: rtl/choose_select_ctrl_pkg.sv
// Shared definitions for the choose-scene selection controller:
// FSM states, grid geometry and key-priority indices.
package choose_select_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BROWSE,
      ST_HANDOFF
   } state_t;

   localparam int unsigned GRID_COLS = 4;
   localparam int unsigned GRID_ROWS = 2;
   localparam int unsigned ID_MIN    = 1;
   localparam int unsigned ID_MAX    = 8;
   localparam int unsigned MASK_W    = ID_MAX + 1;
   localparam int unsigned COL_W     = $clog2(GRID_COLS);
   localparam int unsigned ROW_W     = $clog2(GRID_ROWS);

   // Key indices; a lower index means a higher priority.
   localparam int unsigned KEY_ENTER = 0;
   localparam int unsigned KEY_BACK  = 1;
   localparam int unsigned KEY_UP    = 2;
   localparam int unsigned KEY_DOWN  = 3;
   localparam int unsigned KEY_LEFT  = 4;
   localparam int unsigned KEY_RIGHT = 5;
   localparam int unsigned NUM_KEYS  = 6;

   localparam int unsigned MOVE_UP    = 0;
   localparam int unsigned MOVE_DOWN  = 1;
   localparam int unsigned MOVE_LEFT  = 2;
   localparam int unsigned MOVE_RIGHT = 3;
   localparam int unsigned NUM_MOVES  = 4;

   // Isolate the lowest set bit, i.e. the highest-priority pressed key.
   function automatic logic [NUM_KEYS-1:0] key_arbitrate(input logic [NUM_KEYS-1:0] keys);
      return keys & (~keys + NUM_KEYS'(1));
   endfunction

endpackage

// File: rtl/choose_select_ctrl_if.sv
// Key, cursor and team handoff signals between the input stage,
// the selection controller and the game FSM.
interface choose_select_if #(
   parameter int unsigned TEAM_SIZE = 3,
   parameter int unsigned ID_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH = 4
);
   logic                          start;
   logic                          key_up;
   logic                          key_down;
   logic                          key_left;
   logic                          key_right;
   logic                          key_enter;
   logic                          key_back;
   logic [ID_WIDTH-1:0]           pokemon_id;
   logic [8:0]                    picked_mask;
   logic [TEAM_SIZE*ID_WIDTH-1:0] team_ids;
   logic [CNT_WIDTH-1:0]          team_count;
   logic                          sel_valid;
   logic                          sel_ready;
   logic                          busy;
   logic                          dup_err;

   modport master (
      output start, key_up, key_down, key_left, key_right, key_enter, key_back, sel_ready,
      input  pokemon_id, picked_mask, team_ids, team_count, sel_valid, busy, dup_err
   );

   modport slave (
      input  start, key_up, key_down, key_left, key_right, key_enter, key_back, sel_ready,
      output pokemon_id, picked_mask, team_ids, team_count, sel_valid, busy, dup_err
   );
endinterface

// File: rtl/choose_select_ctrl_cursor_nav.sv
// Combinational cursor wrap rules for the 4x2 grid: current id plus a
// one-hot move gives the next id (no move returns the current id).
module choose_cursor_nav
   import choose_select_ctrl_pkg::*;
#(
   parameter int unsigned ID_WIDTH = 8
) (
   input  logic [ID_WIDTH-1:0]  cur_id,
   input  logic [NUM_MOVES-1:0] move,
   output logic [ID_WIDTH-1:0]  next_id
);

   logic [ROW_W+COL_W-1:0] idx;
   logic [ROW_W-1:0]       row;
   logic [COL_W-1:0]       col;

   // Zero-based id splits into {row, col}; column arithmetic wraps in-row.
   always_comb begin
      idx = (ROW_W+COL_W)'(cur_id - ID_WIDTH'(ID_MIN));
      row = idx[ROW_W+COL_W-1:COL_W];
      col = idx[COL_W-1:0];
      if (move[MOVE_UP] || move[MOVE_DOWN]) begin
         row = ~row;
      end else if (move[MOVE_LEFT]) begin
         col = col - COL_W'(1);
      end else if (move[MOVE_RIGHT]) begin
         col = col + COL_W'(1);
      end
      next_id = ID_WIDTH'({row, col}) + ID_WIDTH'(ID_MIN);
   end

endmodule

// File: rtl/choose_select_ctrl.sv
// Choose-scene selection controller: key pulses move the grid cursor,
// enter/back build a team of distinct ids, finished team handed off via valid/ready.
module choose_select_ctrl
   import choose_select_ctrl_pkg::*;
#(
   parameter int unsigned TEAM_SIZE = 3,
   parameter int unsigned ID_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH = 4
) (
   input logic            clk,
   input logic            rst,
   choose_select_if.slave bus
);

   state_t                 state_q;
   logic [ID_WIDTH-1:0]    cursor_q;
   logic [MASK_W-1:0]      picked_q;
   logic [ID_WIDTH-1:0]    team_q [TEAM_SIZE];
   logic [CNT_WIDTH-1:0]   count_q;
   logic                   valid_q;
   logic                   busy_q;
   logic                   dup_q;

   logic [NUM_KEYS-1:0]    key_vec;
   logic [NUM_KEYS-1:0]    key_win;
   logic [NUM_MOVES-1:0]   move;
   logic [ID_WIDTH-1:0]    nav_id;
   logic [MASK_W-1:0]      cur_bit;
   logic [MASK_W-1:0]      last_bit;
   logic                   cur_picked;
   logic                   team_full_next;
   logic [TEAM_SIZE*ID_WIDTH-1:0] team_flat;

   always_comb begin
      key_vec            = '0;
      key_vec[KEY_ENTER] = bus.key_enter;
      key_vec[KEY_BACK]  = bus.key_back;
      key_vec[KEY_UP]    = bus.key_up;
      key_vec[KEY_DOWN]  = bus.key_down;
      key_vec[KEY_LEFT]  = bus.key_left;
      key_vec[KEY_RIGHT] = bus.key_right;
      key_win            = key_arbitrate(key_vec);

      move             = '0;
      move[MOVE_UP]    = key_win[KEY_UP];
      move[MOVE_DOWN]  = key_win[KEY_DOWN];
      move[MOVE_LEFT]  = key_win[KEY_LEFT];
      move[MOVE_RIGHT] = key_win[KEY_RIGHT];
   end

   choose_cursor_nav #(
      .ID_WIDTH (ID_WIDTH)
   ) u_nav (
      .cur_id  (cursor_q),
      .move    (move),
      .next_id (nav_id)
   );

   always_comb begin
      cur_bit        = MASK_W'(1) << cursor_q;
      cur_picked     = |(picked_q & cur_bit);
      team_full_next = (count_q + CNT_WIDTH'(1)) == CNT_WIDTH'(TEAM_SIZE);
      last_bit       = '0;
      for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
         if (count_q == CNT_WIDTH'(i + 1)) begin
            last_bit = MASK_W'(1) << team_q[i];
         end
         team_flat[i*ID_WIDTH +: ID_WIDTH] = team_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cursor_q <= ID_WIDTH'(ID_MIN);
         picked_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         dup_q    <= 1'b0;
         for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
            team_q[i] <= '0;
         end
      end else begin
         dup_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q  <= ST_BROWSE;
                  cursor_q <= ID_WIDTH'(ID_MIN);
                  picked_q <= '0;
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                     team_q[i] <= '0;
                  end
               end
            end

            ST_BROWSE: begin
               cursor_q <= nav_id;
               if (key_win[KEY_ENTER]) begin
                  if (cur_picked) begin
                     dup_q <= 1'b1;
                  end else begin
                     for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                        if (count_q == CNT_WIDTH'(i)) team_q[i] <= cursor_q;
                     end
                     picked_q <= picked_q | cur_bit;
                     count_q  <= count_q + CNT_WIDTH'(1);
                     if (team_full_next) begin
                        state_q <= ST_HANDOFF;
                        valid_q <= 1'b1;
                     end
                  end
               end else if (key_win[KEY_BACK] && count_q != '0) begin
                  for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                     if (count_q == CNT_WIDTH'(i + 1)) team_q[i] <= '0;
                  end
                  picked_q <= picked_q & ~last_bit;
                  count_q  <= count_q - CNT_WIDTH'(1);
               end
            end

            ST_HANDOFF: begin
               // Transfer takes precedence over back; enter is simply swallowed.
               cursor_q <= nav_id;
               if (bus.sel_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (key_win[KEY_BACK]) begin
                  for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                     if (count_q == CNT_WIDTH'(i + 1)) team_q[i] <= '0;
                  end
                  picked_q <= picked_q & ~last_bit;
                  count_q  <= count_q - CNT_WIDTH'(1);
                  valid_q  <= 1'b0;
                  state_q  <= ST_BROWSE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.pokemon_id  = cursor_q;
   assign bus.picked_mask = picked_q;
   assign bus.team_ids    = team_flat;
   assign bus.team_count  = count_q;
   assign bus.sel_valid   = valid_q;
   assign bus.busy        = busy_q;
   assign bus.dup_err     = dup_q;

endmodule

// File: tb/tb_choose_select_ctrl.sv
// Bench for choose_select_ctrl: directed scenarios then random key traffic,
// every cycle compared against a queue-based behavioural model.
module tb_choose_select_ctrl;

   localparam int unsigned TEAM_SIZE = 3;
   localparam int unsigned ID_WIDTH  = 8;
   localparam int unsigned CNT_WIDTH = 4;

   localparam logic [5:0] K_ENTER = 6'b000001;
   localparam logic [5:0] K_BACK  = 6'b000010;
   localparam logic [5:0] K_UP    = 6'b000100;
   localparam logic [5:0] K_DOWN  = 6'b001000;
   localparam logic [5:0] K_LEFT  = 6'b010000;
   localparam logic [5:0] K_RIGHT = 6'b100000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state
   int m_cur = 1;
   int m_team[$];
   bit m_active = 0;
   bit m_valid  = 0;
   bit m_dup    = 0;

   choose_select_if #(
      .TEAM_SIZE (TEAM_SIZE),
      .ID_WIDTH  (ID_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) bus ();

   choose_select_ctrl #(
      .TEAM_SIZE (TEAM_SIZE),
      .ID_WIDTH  (ID_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int moved(input int c, input logic [5:0] k);
      if (k[2] || k[3]) return (c <= 4) ? c + 4 : c - 4;
      if (k[4]) return ((c - 1) % 4 == 0) ? c + 3 : c - 1;
      if (k[5]) return (c % 4 == 0) ? c - 3 : c + 1;
      return c;
   endfunction

   function automatic bit in_team(input int id);
      foreach (m_team[i]) if (m_team[i] == id) return 1;
      return 0;
   endfunction

   task automatic model_step(input logic st, input logic [5:0] k, input logic rdy, input logic r);
      m_dup = 0;
      if (r) begin
         m_cur = 1; m_team.delete(); m_active = 0; m_valid = 0;
      end else if (!m_active) begin
         if (st) begin
            m_cur = 1; m_team.delete(); m_active = 1; m_valid = 0;
         end
      end else begin
         if (!m_valid) begin
            if (k[0]) begin
               if (in_team(m_cur)) m_dup = 1;
               else begin
                  m_team.push_back(m_cur);
                  if (m_team.size() == TEAM_SIZE) m_valid = 1;
               end
            end else if (k[1]) begin
               if (m_team.size() > 0) void'(m_team.pop_back());
            end
         end else begin
            if (rdy) begin
               m_active = 0; m_valid = 0;
            end else if (!k[0] && k[1]) begin
               void'(m_team.pop_back());
               m_valid = 0;
            end
         end
         if (!k[0] && !k[1]) m_cur = moved(m_cur, k);
      end
   endtask

   task automatic compare_all();
      logic [31:0] mask = '0;
      logic [31:0] ids  = '0;
      foreach (m_team[i]) begin
         mask = mask | (32'd1 << m_team[i]);
         ids  = ids | (32'(m_team[i]) << (8 * i));
      end
      check("pokemon_id",  32'(bus.pokemon_id),  32'(m_cur));
      check("picked_mask", 32'(bus.picked_mask), mask);
      check("team_ids",    32'(bus.team_ids),    ids);
      check("team_count",  32'(bus.team_count),  32'(m_team.size()));
      check("sel_valid",   32'(bus.sel_valid),   32'(m_valid));
      check("busy",        32'(bus.busy),        32'(m_active));
      check("dup_err",     32'(bus.dup_err),     32'(m_dup));
   endtask

   task automatic step(input logic st, input logic [5:0] k, input logic rdy, input logic r);
      bus.start     = st;
      bus.key_enter = k[0];
      bus.key_back  = k[1];
      bus.key_up    = k[2];
      bus.key_down  = k[3];
      bus.key_left  = k[4];
      bus.key_right = k[5];
      bus.sel_ready = rdy;
      rst           = r;
      @(posedge clk);
      model_step(st, k, rdy, r);
      #1;
      compare_all();
   endtask

   task automatic key(input logic [5:0] k);
      step(1'b0, k, 1'b0, 1'b0);
   endtask

   // From cursor 1 in BROWSE: pick 1, 6, 8.
   task automatic pick_168();
      key(K_ENTER);
      key(K_DOWN);
      key(K_RIGHT);
      key(K_ENTER);
      key(K_RIGHT);
      key(K_RIGHT);
      key(K_ENTER);
   endtask

   initial begin
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      check("rst_id",   32'(bus.pokemon_id), 32'd1);
      check("rst_busy", 32'(bus.busy),       32'd0);
      key(K_RIGHT);
      check("idle_ignores_keys", 32'(bus.pokemon_id), 32'd1);

      // Cursor walk
      step(1'b1, '0, 1'b0, 1'b0);
      check("start_busy", 32'(bus.busy), 32'd1);
      key(K_RIGHT); check("right_1", 32'(bus.pokemon_id), 32'd2);
      key(K_RIGHT); check("right_2", 32'(bus.pokemon_id), 32'd3);
      key(K_RIGHT); check("right_3", 32'(bus.pokemon_id), 32'd4);
      key(K_RIGHT); check("right_wrap", 32'(bus.pokemon_id), 32'd1);
      key(K_LEFT);  check("left_wrap", 32'(bus.pokemon_id), 32'd4);
      key(K_DOWN);  check("down", 32'(bus.pokemon_id), 32'd8);
      key(K_UP);    check("up", 32'(bus.pokemon_id), 32'd4);

      // Simultaneous keys at cursor 3
      key(K_LEFT);
      key(K_ENTER | K_LEFT | K_RIGHT);
      check("prio_slot0", 32'(bus.team_ids),   32'd3);
      check("prio_count", 32'(bus.team_count), 32'd1);
      check("prio_cur",   32'(bus.pokemon_id), 32'd3);

      // Duplicate pick at 2
      key(K_BACK);
      key(K_LEFT);
      key(K_ENTER);
      key(K_ENTER);
      check("dup_hi", 32'(bus.dup_err), 32'd1);
      key('0);
      check("dup_lo",    32'(bus.dup_err),     32'd0);
      check("dup_count", 32'(bus.team_count),  32'd1);
      check("dup_mask",  32'(bus.picked_mask), 32'h004);

      // Full team 1,6,8 and held handoff
      key(K_BACK);
      key(K_LEFT);
      pick_168();
      check("full_valid", 32'(bus.sel_valid), 32'd1);
      check("full_team",  32'(bus.team_ids),  32'h080601);
      repeat (5) key('0);
      check("hold_team", 32'(bus.team_ids), 32'h080601);
      step(1'b0, '0, 1'b1, 1'b0);
      check("xfer_busy",  32'(bus.busy),      32'd0);
      check("xfer_valid", 32'(bus.sel_valid), 32'd0);

      // Cancel in handoff, then back+ready together
      step(1'b1, '0, 1'b0, 1'b0);
      pick_168();
      key(K_BACK);
      check("cancel_valid", 32'(bus.sel_valid),   32'd0);
      check("cancel_count", 32'(bus.team_count),  32'd2);
      check("cancel_mask",  32'(bus.picked_mask), 32'h042);
      key(K_ENTER);
      step(1'b0, K_BACK, 1'b1, 1'b0);
      check("backrdy_count", 32'(bus.team_count), 32'd3);
      check("backrdy_busy",  32'(bus.busy),       32'd0);

      // Reset mid-handoff
      step(1'b1, '0, 1'b0, 1'b0);
      pick_168();
      step(1'b0, K_ENTER, 1'b0, 1'b1);
      check("midrst_count", 32'(bus.team_count), 32'd0);
      check("midrst_valid", 32'(bus.sel_valid),  32'd0);
      key(K_DOWN);
      key(K_ENTER);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] k;
         logic       st;
         logic       rdy;
         logic       r;
         k   = 6'($urandom) & 6'($urandom);
         st  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) == 0);
         r   = ($urandom_range(0, 299) == 0);
         step(st, k, rdy, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
